// File: rtl/jtframe_lfbuf_psram.sv
// Responder model of the CellularRAM (PSRAM) chip behind the line-frame-buffer
// controller: decodes the cr_* bus, holds BCR/RCR and serves synchronous
// bursts from an internal 2^AW x 16 array split into two byte lanes.
module jtframe_lfbuf_psram #(
   parameter int          AW      = 17,
   parameter logic [15:0] BCR_RST = 16'h9D1F,
   parameter logic [15:0] RCR_RST = 16'h0010
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [5:0]  cr_addr,
   inout  wire  [15:0] cr_adq,
   input  logic        cr_advn,
   input  logic        cr_cre,
   input  logic [1:0]  cr_cen,
   input  logic        cr_oen,
   input  logic        cr_wen,
   input  logic [1:0]  cr_dsn,
   output logic        cr_wait,
   output logic [15:0] bcr,
   output logic [15:0] rcr,
   output logic        err
);

   typedef enum logic [2:0] {IDLE, LAT, RD_BURST, WR_BURST, REG_WR, HOLD} state_t;

   state_t        state_reg, state_next;
   logic [AW-1:0] addr_reg, addr_next;
   logic [AW-1:0] mask_reg, mask_next;
   logic [2:0]    lc_reg, lc_next;
   logic [2:0]    k_reg, k_next;
   logic          cre_reg, cre_next;
   logic          wen_reg, wen_next;
   logic [1:0]    sel_reg, sel_next;
   logic [15:0]   alo_reg, alo_next;
   logic [15:0]   bcr_reg, bcr_next;
   logic [15:0]   rcr_reg, rcr_next;
   logic [15:0]   regq_reg, regq_next;
   logic          err_reg, err_next;
   logic          wait_reg, wait_next;
   logic          wait_valid, rd_load, mem_we, mem_re, drive;
   logic [21:0]   full_a;
   logic [2:0]    lc_eff;
   logic [AW-1:0] mask_eff, addr_inc;
   logic [15:0]   mem_q;
   logic          unused_bits;

   assign full_a      = {cr_addr, cr_adq};
   assign unused_bits = ^full_a;

   // Latency and wrap window derived from the BCR; sampled only at address latch
   always_comb begin
      lc_eff = bcr_reg[13:11];
      if (bcr_reg[13:11] == 3'd0 || bcr_reg[13:11] == 3'd1 || bcr_reg[13:11] == 3'd7)
         lc_eff = 3'd3;
      mask_eff = '1;
      if (!bcr_reg[3]) begin
         case (bcr_reg[2:0])
            3'd1:    mask_eff = AW'(32'd3);
            3'd2:    mask_eff = AW'(32'd7);
            3'd3:    mask_eff = AW'(32'd15);
            3'd4:    mask_eff = AW'(32'd31);
            default: mask_eff = '1;
         endcase
      end
   end

   // Next burst address: low bits inside the wrap window advance, upper bits hold
   assign addr_inc = (addr_reg & ~mask_reg) |
                     ((addr_reg + {{(AW-1){1'b0}}, 1'b1}) & mask_reg);

   // Next-state and datapath decisions; cen[0] high beats everything, then a new latch
   always_comb begin
      state_next = state_reg;
      addr_next  = addr_reg;
      mask_next  = mask_reg;
      lc_next    = lc_reg;
      k_next     = k_reg;
      cre_next   = cre_reg;
      wen_next   = wen_reg;
      sel_next   = sel_reg;
      alo_next   = alo_reg;
      bcr_next   = bcr_reg;
      rcr_next   = rcr_reg;
      regq_next  = regq_reg;
      err_next   = err_reg | ~cr_cen[1];
      wait_valid = 1'b0;
      rd_load    = 1'b0;
      mem_we     = 1'b0;
      if (cr_cen[0]) begin
         state_next = IDLE;
      end else if (!cr_advn) begin
         addr_next = full_a[AW-1:0];
         alo_next  = cr_adq;
         sel_next  = cr_addr[3:2];
         cre_next  = cr_cre;
         wen_next  = cr_wen;
         lc_next   = lc_eff;
         mask_next = mask_eff;
         k_next    = 3'd1;
         if (cr_cre) begin
            if (!cr_wen)
               state_next = REG_WR;
            else if (cr_addr[3:2] == 2'd2 || cr_addr[3:2] == 2'd0)
               state_next = LAT;
            else
               state_next = HOLD;
         end else if (bcr_reg[15]) begin
            err_next   = 1'b1;
            state_next = HOLD;
         end else begin
            state_next = LAT;
         end
      end else begin
         case (state_reg)
            LAT: begin
               // One edge before the first beat: fetch beat 0 and flag data valid
               if (k_reg == lc_reg - 3'd1) begin
                  wait_valid = 1'b1;
                  if (wen_reg) begin
                     state_next = RD_BURST;
                     rd_load    = 1'b1;
                  end else begin
                     state_next = WR_BURST;
                  end
               end else begin
                  k_next = k_reg + 3'd1;
               end
            end
            RD_BURST: begin
               wait_valid = 1'b1;
               rd_load    = 1'b1;
            end
            WR_BURST: begin
               wait_valid = 1'b1;
               mem_we     = 1'b1;
               addr_next  = addr_inc;
               if (!cr_oen) err_next = 1'b1;
            end
            REG_WR: begin
               if (!cr_wen) begin
                  if (sel_reg == 2'd2)      bcr_next = alo_reg;
                  else if (sel_reg == 2'd0) rcr_next = alo_reg;
                  state_next = HOLD;
               end
            end
            default: ;
         endcase
      end
      if (rd_load) begin
         addr_next = addr_inc;
         regq_next = (sel_reg == 2'd2) ? bcr_reg : rcr_reg;
      end
      wait_next = wait_valid ? ~bcr_reg[10] : bcr_reg[10];
   end

   // State and control registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         addr_reg  <= '0;
         mask_reg  <= '1;
         lc_reg    <= 3'd3;
         k_reg     <= 3'd0;
         cre_reg   <= 1'b0;
         wen_reg   <= 1'b1;
         sel_reg   <= 2'd0;
         alo_reg   <= 16'd0;
         bcr_reg   <= BCR_RST;
         rcr_reg   <= RCR_RST;
         regq_reg  <= 16'd0;
         err_reg   <= 1'b0;
         wait_reg  <= BCR_RST[10];
      end else begin
         state_reg <= state_next;
         addr_reg  <= addr_next;
         mask_reg  <= mask_next;
         lc_reg    <= lc_next;
         k_reg     <= k_next;
         cre_reg   <= cre_next;
         wen_reg   <= wen_next;
         sel_reg   <= sel_next;
         alo_reg   <= alo_next;
         bcr_reg   <= bcr_next;
         rcr_reg   <= rcr_next;
         regq_reg  <= regq_next;
         err_reg   <= err_next;
         wait_reg  <= wait_next;
      end
   end

   assign mem_re = rd_load & ~cre_reg;

   // One block RAM per byte lane so the byte strobes map to plain write enables
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_lane
         logic [7:0] mem [0:(1<<AW)-1];
         logic [7:0] q_reg;
         // Lane write on active strobe, registered read for the next beat
         always_ff @(posedge clk) begin
            if (mem_we && !cr_dsn[gi]) mem[addr_reg] <= cr_adq[gi*8 +: 8];
            if (mem_re) q_reg <= mem[addr_reg];
         end
         assign mem_q[gi*8 +: 8] = q_reg;
      end
   endgenerate

   assign drive   = (state_reg == RD_BURST) && !cr_cen[0] && !cr_oen && cr_advn;
   assign cr_adq  = drive ? (cre_reg ? regq_reg : mem_q) : 16'hzzzz;
   assign cr_wait = wait_reg;
   assign bcr     = bcr_reg;
   assign rcr     = rcr_reg;
   assign err     = err_reg;

endmodule

// File: tb/tb_jtframe_lfbuf_psram.sv
// Directed and randomized bursts against a behavioural PSRAM model.
module tb_jtframe_lfbuf_psram;
   localparam int AW = 17;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [5:0]  cr_addr = '0;
   logic        cr_advn = 1'b1, cr_cre = 1'b0, cr_oen = 1'b1, cr_wen = 1'b1;
   logic [1:0]  cr_cen = 2'b11, cr_dsn = 2'b11;
   logic        cr_wait, err;
   logic [15:0] bcr, rcr;
   logic [15:0] adq_drv = '0;
   logic        adq_oe = 1'b0;
   wire  [15:0] cr_adq;

   assign cr_adq = adq_oe ? adq_drv : 16'hzzzz;

   always #5 clk = ~clk;

   jtframe_lfbuf_psram #(.AW(AW), .BCR_RST(16'h9D1F), .RCR_RST(16'h0010)) dut (
      .clk(clk), .rst_n(rst_n), .cr_addr(cr_addr), .cr_adq(cr_adq),
      .cr_advn(cr_advn), .cr_cre(cr_cre), .cr_cen(cr_cen), .cr_oen(cr_oen),
      .cr_wen(cr_wen), .cr_dsn(cr_dsn), .cr_wait(cr_wait), .bcr(bcr),
      .rcr(rcr), .err(err)
   );

   int          checks = 0;
   int          errors = 0;
   logic [15:0] bcr_m, rcr_m;
   logic [15:0] mdl [int];
   logic [15:0] wq [$];

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   function automatic int lc_of(input logic [15:0] b);
      int l;
      l = int'(b[13:11]);
      if (l == 0 || l == 1 || l == 7) l = 3;
      return l;
   endfunction

   // Word address of beat n for a burst starting at a
   function automatic int baddr(input int a, input int n, input logic [15:0] b);
      int bl, sz;
      bl = int'(b[2:0]);
      if (b[3] || bl < 1 || bl > 4) return (a + n) % (1 << AW);
      sz = 4 << (bl - 1);
      return (a - (a % sz)) + ((a % sz + n) % sz);
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; cr_cen = 2'b11; cr_advn = 1'b1; cr_oen = 1'b1; cr_wen = 1'b1;
      cr_cre = 1'b0; cr_dsn = 2'b11; adq_oe = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      bcr_m = 16'h9D1F;
      rcr_m = 16'h0010;
      @(negedge clk);
      $display("txn reset");
      chk("rst_bcr", bcr, bcr_m);
      chk("rst_rcr", rcr, rcr_m);
      chk("rst_err", {15'd0, err}, 16'd0);
      chk("rst_wait", {15'd0, cr_wait}, {15'd0, bcr_m[10]});
   endtask

   task automatic reg_write(input logic [21:0] a);
      $display("txn regwr addr=%06h", a);
      @(negedge clk);
      cr_cen = 2'b10; cr_advn = 1'b0; cr_cre = 1'b1; cr_wen = 1'b0;
      cr_addr = a[21:16]; adq_drv = a[15:0]; adq_oe = 1'b1;
      @(negedge clk);
      cr_advn = 1'b1; cr_cre = 1'b0;
      @(negedge clk);
      cr_wen = 1'b1; cr_cen = 2'b11; adq_oe = 1'b0;
      if (a[19:18] == 2'd2) bcr_m = a[15:0];
      else if (a[19:18] == 2'd0) rcr_m = a[15:0];
      @(negedge clk);
      chk("reg_bcr", bcr, bcr_m);
      chk("reg_rcr", rcr, rcr_m);
      chk("idle_wait", {15'd0, cr_wait}, {15'd0, bcr_m[10]});
   endtask

   task automatic burst(input bit wr, input bit cre_b, input logic [21:0] a, input int n,
                        input logic [1:0] dsn_b, input bit end_it);
      int          lc, aa, ba;
      bit          async_acc;
      logic [15:0] regv, d, nv;
      logic        wexp;
      lc = lc_of(bcr_m);
      async_acc = !cre_b && bcr_m[15];
      aa = int'(a[AW-1:0]);
      regv = (a[19:18] == 2'd2) ? bcr_m : rcr_m;
      $display("txn %s %s addr=%06h beats=%0d lc=%0d dsn=%b", wr ? "write" : "read",
               cre_b ? "reg" : "arr", a, n, lc, dsn_b);
      @(negedge clk);
      cr_cen = 2'b10; cr_advn = 1'b0; cr_cre = cre_b; cr_wen = !wr;
      cr_addr = a[21:16]; adq_drv = a[15:0]; adq_oe = 1'b1; cr_oen = 1'b1; cr_dsn = 2'b11;
      for (int k = 1; k < lc + n; k++) begin
         @(negedge clk);
         wexp = (!async_acc && k >= lc) ? ~bcr_m[10] : bcr_m[10];
         chk("wait", {15'd0, cr_wait}, {15'd0, wexp});
         if (k == 1) begin
            cr_advn = 1'b1; cr_cre = 1'b0;
            if (!wr) begin adq_oe = 1'b0; cr_oen = 1'b0; end
         end
         if (k >= lc) begin
            ba = baddr(aa, k - lc, bcr_m);
            if (wr) begin
               d = wq.pop_front();
               adq_drv = d; cr_dsn = dsn_b;
               if (!async_acc) begin
                  nv = mdl.exists(ba) ? mdl[ba] : d;
                  if (!dsn_b[0]) nv[7:0]  = d[7:0];
                  if (!dsn_b[1]) nv[15:8] = d[15:8];
                  mdl[ba] = nv;
               end
            end else if (cre_b) begin
               chk("reg_rd", cr_adq, regv);
            end else if (mdl.exists(ba)) begin
               chk("arr_rd", cr_adq, mdl[ba]);
            end
         end
      end
      if (end_it) begin
         @(negedge clk);
         cr_cen = 2'b11; cr_advn = 1'b1; cr_oen = 1'b1; cr_wen = 1'b1;
         cr_dsn = 2'b11; adq_oe = 1'b0;
      end
   endtask

   task automatic push_seq(input int n, input logic [15:0] base);
      for (int i = 0; i < n; i++) wq.push_back(base + 16'(i));
   endtask

   task automatic push_rand(input int n);
      for (int i = 0; i < n; i++) wq.push_back(16'($urandom));
   endtask

   initial begin
      logic [15:0] rb;
      logic [21:0] ra;
      int          rn;

      // Reset and register access
      do_reset();
      reg_write({6'h08, 16'h1D0F});
      burst(0, 1, {6'h08, 16'h0000}, 3, 2'b11, 1);
      reg_write({6'h00, 16'h0055});
      burst(0, 1, {6'h00, 16'h0000}, 2, 2'b11, 1);

      // Asynchronous-mode array access is ignored and flags err
      wq.push_back(16'hBEEF);
      burst(1, 0, 22'h000100, 1, 2'b00, 1);
      do_reset();
      wq.push_back(16'h1111); wq.push_back(16'h2222);
      burst(1, 0, 22'h000100, 2, 2'b00, 1);
      @(negedge clk);
      chk("err_async", {15'd0, err}, 16'd1);
      do_reset();
      reg_write({6'h08, 16'h1D0F});
      burst(0, 0, 22'h000100, 1, 2'b11, 1);

      // 512-word continuous burst wrapping past the top of the array
      push_seq(512, 16'h0000);
      burst(1, 0, 22'h01FF00, 512, 2'b00, 1);
      burst(0, 0, 22'h01FF00, 512, 2'b11, 1);

      // Byte strobes: only the low byte is replaced
      wq.push_back(16'h1234);
      burst(1, 0, 22'h000040, 1, 2'b00, 1);
      wq.push_back(16'hABCD);
      burst(1, 0, 22'h000040, 1, 2'b10, 1);
      burst(0, 0, 22'h000040, 1, 2'b11, 1);
      chk("dsn_word", mdl[32'h40], 16'h12CD);

      // 4-word wrap: beats at 6,7,4,5,6
      reg_write({6'h08, 16'h1D01});
      push_rand(4);
      burst(1, 0, 22'h000004, 4, 2'b00, 1);
      burst(0, 0, 22'h000006, 5, 2'b11, 1);

      // Abort mid-read, relatch a write, and relatch without raising cen
      reg_write({6'h08, 16'h1D0F});
      push_rand(16);
      burst(1, 0, 22'h000200, 16, 2'b00, 1);
      burst(0, 0, 22'h000200, 5, 2'b11, 1);
      push_rand(2);
      burst(1, 0, 22'h000300, 2, 2'b00, 1);
      burst(0, 0, 22'h000208, 3, 2'b11, 0);
      push_rand(1);
      burst(1, 0, 22'h000310, 1, 2'b00, 1);
      burst(0, 0, 22'h000300, 2, 2'b11, 1);
      burst(0, 0, 22'h000310, 1, 2'b11, 1);
      @(negedge clk);
      chk("err_clean", {15'd0, err}, 16'd0);

      // Random configurations, addresses and lengths
      for (int it = 0; it < 8; it++) begin
         rb = {2'b00, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 6'd0,
               1'($urandom_range(0, 1)), 3'($urandom_range(0, 7))};
         reg_write({6'h08, rb});
         ra = 22'($urandom);
         rn = $urandom_range(1, 12);
         push_rand(rn);
         burst(1, 0, ra, rn, 2'b00, 1);
         burst(0, 0, ra, rn, 2'b11, 1);
      end

      // err from oen low during a write burst, then from cen[1] low
      reg_write({6'h08, 16'h1D0F});
      @(negedge clk);
      cr_cen = 2'b10; cr_advn = 1'b0; cr_wen = 1'b0; cr_cre = 1'b0;
      cr_addr = 6'h00; adq_drv = 16'h3F00; adq_oe = 1'b1;
      @(negedge clk);
      cr_advn = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         cr_oen = 1'b0;
      end
      cr_cen = 2'b11; cr_oen = 1'b1; cr_wen = 1'b1; adq_oe = 1'b0;
      @(negedge clk);
      chk("err_oen", {15'd0, err}, 16'd1);
      do_reset();
      cr_cen = 2'b01;
      @(negedge clk);
      cr_cen = 2'b11;
      @(negedge clk);
      chk("err_cen1", {15'd0, err}, 16'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
